// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM access controller.
// Holds the FSM state encoding, default bus widths and the skip counter width,
// plus a helper that sizes the latency counter from the two array latencies.
package pcm_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int SKIP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } pcm_state_t;

  // Bits needed to hold max(rd_lat, wr_lat)-1; never less than one bit.
  function automatic int lat_cnt_w(input int rd_lat, input int wr_lat);
    int mx;
    mx = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (mx < 2) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/pcm_lat_counter.sv
// Down-counter that times one array phase (read or write) at a time.
// Latency: load/decrement take effect on the next edge; zero is combinational.
// Backpressure: none; the FSM decides when to load and when to decrement.
module pcm_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pcm_access_ctrl.sv
// Responder for CPU/PCM scheduling: timed array read, then differential write.
// Latency: resolved after READ_LAT edges (read/skip) or READ_LAT+WRITE_LAT (write).
// Backpressure: request is held by the requester; inputs ignored while busy.
module pcm_access_ctrl
  import pcm_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  schedule,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  cpu_write,
  input  logic [DATA_W-1:0]     cpu_in,
  output logic                  resolved,
  output logic [DATA_W-1:0]     data_in,
  output logic                  busy,
  output logic [SKIP_CNT_W-1:0] skip_cnt,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int CNT_W = lat_cnt_w(READ_LAT, WRITE_LAT);

  pcm_state_t state_q, state_d;

  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [SKIP_CNT_W-1:0] skip_cnt_q, skip_cnt_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  // One counter serves both phases; the FSM reloads it at the READ->WRITE hop.
  pcm_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter control and request/data register updates.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    skip_cnt_d   = skip_cnt_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      IDLE: begin
        if (schedule) begin
          addr_d       = addr;
          wr_d         = cpu_write;
          wdata_d      = cpu_in;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(READ_LAT - 1);
          state_d      = READ;
        end
      end
      READ: begin
        if (cnt_zero) begin
          rdata_d = mem_rdata;
          if (!wr_q) begin
            state_d = DONE;
          end else if (mem_rdata == wdata_q) begin
            // Stored word already matches: skip the array write entirely.
            state_d = DONE;
            if (skip_cnt_q != '1) begin
              skip_cnt_d = skip_cnt_q + 1'b1;
            end
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(WRITE_LAT - 1);
            state_d      = WRITE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WRITE: begin
        if (cnt_zero) begin
          rdata_d = wdata_q;
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latches, returned word and skip counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      skip_cnt_q <= '0;
    end else begin
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  // Outputs decoded from state so reset drops the strobes asynchronously.
  always_comb begin
    busy      = (state_q != IDLE);
    resolved  = (state_q == DONE);
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q;
      end
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      default: begin
        mem_rd = 1'b0;
      end
    endcase
  end

  assign data_in  = rdata_q;
  assign skip_cnt = skip_cnt_q;

endmodule

// File: tb/tb_pcm_access_ctrl.sv
// Directed bench for pcm_access_ctrl with a small behavioural PCM array.
// Each request is tracked per cycle: strobe counts, address/data on the bus, resolve cycle.
// Expected values are hand-derived from READ_LAT=4, WRITE_LAT=12.
module tb_pcm_access_ctrl;

  logic        clk;
  logic        reset;
  logic        schedule;
  logic [19:0] addr;
  logic        cpu_write;
  logic [15:0] cpu_in;
  logic        resolved;
  logic [15:0] data_in;
  logic        busy;
  logic [15:0] skip_cnt;
  logic [19:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int n_chk;
  int n_err;

  // Behavioural array: preload port plus write port driven by the DUT.
  logic [15:0] mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_a;
  logic [15:0] pre_d;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (mem_wr) begin
      mem[mem_addr[11:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr[11:0]];

  pcm_access_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .schedule  (schedule),
    .addr      (addr),
    .cpu_write (cpu_write),
    .cpu_in    (cpu_in),
    .resolved  (resolved),
    .data_in   (data_in),
    .busy      (busy),
    .skip_cnt  (skip_cnt),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one request and watches it cycle by cycle. Index i is the cycle after edge E_i.
  // res_at = -1 on timeout, -2 when aborted by reset (reset left high on return).
  task automatic run_req(input logic [19:0] a, input logic w, input logic [15:0] d,
                         input int disturb_at, input int abort_at,
                         output int rd_n, output int wr_n, output int res_at,
                         output logic [15:0] dout, output int bad_n);
    rd_n   = 0;
    wr_n   = 0;
    res_at = -1;
    dout   = '0;
    bad_n  = 0;
    @(negedge clk);
    schedule  = 1'b1;
    addr      = a;
    cpu_write = w;
    cpu_in    = d;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == disturb_at) begin
        addr     = ~a;
        cpu_in   = ~d;
        schedule = 1'b0;
        #1;
      end
      if (i == abort_at) begin
        reset = 1'b1;
        #1;
        res_at = -2;
        break;
      end
      if (mem_rd) begin
        rd_n++;
        if (mem_addr !== a) bad_n++;
      end
      if (mem_wr) begin
        wr_n++;
        if (mem_addr !== a || mem_wdata !== d) bad_n++;
      end
      if (!mem_rd && !mem_wr && (mem_addr !== '0 || mem_wdata !== '0)) bad_n++;
      if (mem_rd && mem_wr) bad_n++;
      if (!busy) bad_n++;
      if (resolved) begin
        res_at   = i;
        dout     = data_in;
        schedule = 1'b0;
        break;
      end
    end
    schedule = 1'b0;
  endtask

  // Cycle after the resolve pulse: back to idle, returned word held.
  task automatic post_chk(input string tag, input logic [15:0] dexp);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_resolved"}, resolved, 0);
    chk({tag, "_hold_data"}, data_in, dexp);
  endtask

  int          rd_n, wr_n, res_at, bad_n, stray;
  logic [15:0] dout;

  initial begin
    n_chk     = 0;
    n_err     = 0;
    reset     = 1'b1;
    schedule  = 1'b0;
    addr      = '0;
    cpu_write = 1'b0;
    cpu_in    = '0;
    pre_we    = 1'b0;
    pre_a     = '0;
    pre_d     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resolved", resolved, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_skip_cnt", skip_cnt, 0);
    reset = 1'b0;

    preload(12'h123, 16'hBEEF);
    preload(12'h456, 16'h0000);
    preload(12'h789, 16'h5A5A);
    preload(12'hABC, 16'h1111);
    preload(12'hDEF, 16'h0000);
    preload(12'h321, 16'h0000);

    // Plain read of 0xBEEF
    run_req(20'h00123, 1'b0, 16'h0000, -1, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("rd_rd_cycles", rd_n, 4);
    chk("rd_wr_cycles", wr_n, 0);
    chk("rd_resolve_at", res_at, 4);
    chk("rd_data", dout, 16'hBEEF);
    chk("rd_bus", bad_n, 0);
    chk("rd_skip", skip_cnt, 0);
    post_chk("rd", 16'hBEEF);

    // Performed write 0x1234 over 0x0000
    run_req(20'h00456, 1'b1, 16'h1234, -1, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("wr_rd_cycles", rd_n, 4);
    chk("wr_wr_cycles", wr_n, 12);
    chk("wr_resolve_at", res_at, 16);
    chk("wr_data", dout, 16'h1234);
    chk("wr_bus", bad_n, 0);
    chk("wr_skip", skip_cnt, 0);
    post_chk("wr", 16'h1234);

    // Skipped write: location already holds 0x5A5A
    run_req(20'h00789, 1'b1, 16'h5A5A, -1, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("skip_rd_cycles", rd_n, 4);
    chk("skip_wr_cycles", wr_n, 0);
    chk("skip_resolve_at", res_at, 4);
    chk("skip_data", dout, 16'h5A5A);
    chk("skip_bus", bad_n, 0);
    chk("skip_cnt_1", skip_cnt, 1);
    post_chk("skip", 16'h5A5A);

    // Inputs disturbed and schedule dropped during WRITE
    run_req(20'h00ABC, 1'b1, 16'h2222, 6, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("dist_wr_cycles", wr_n, 12);
    chk("dist_resolve_at", res_at, 16);
    chk("dist_data", dout, 16'h2222);
    chk("dist_bus", bad_n, 0);
    post_chk("dist", 16'h2222);

    // Reset during WRITE cycle 5
    run_req(20'h00321, 1'b1, 16'h7777, -1, 8, rd_n, wr_n, res_at, dout, bad_n);
    chk("abort_taken", res_at, -2);
    chk("abort_mem_wr", mem_wr, 0);
    chk("abort_mem_rd", mem_rd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_resolved", resolved, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_data_in", data_in, 0);
    chk("abort_skip_cnt", skip_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resolved || busy || mem_wr) stray++;
    end
    chk("abort_no_resolve", stray, 0);

    // Fresh read after reset
    run_req(20'h00123, 1'b0, 16'h0000, -1, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("fresh_resolve_at", res_at, 4);
    chk("fresh_data", dout, 16'hBEEF);
    chk("fresh_bus", bad_n, 0);

    // Array contents after earlier writes
    run_req(20'h00456, 1'b0, 16'h0000, -1, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("readback_456", dout, 16'h1234);
    run_req(20'h00ABC, 1'b0, 16'h0000, -1, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("readback_abc", dout, 16'h2222);
    run_req(20'h00DEF, 1'b0, 16'h0000, -1, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("readback_def", dout, 16'h0000);

    // Skip counter saturation, starting just below the ceiling
    @(negedge clk);
    dut.skip_cnt_q = 16'hFFFD;
    run_req(20'h00789, 1'b1, 16'h5A5A, -1, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("sat_fffe", skip_cnt, 16'hFFFE);
    run_req(20'h00789, 1'b1, 16'h5A5A, -1, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("sat_ffff", skip_cnt, 16'hFFFF);
    run_req(20'h00789, 1'b1, 16'h5A5A, -1, -1, rd_n, wr_n, res_at, dout, bad_n);
    chk("sat_hold", skip_cnt, 16'hFFFF);
    chk("sat_wr_cycles", wr_n, 0);
    chk("sat_resolve_at", res_at, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
